// File: rtl/motor_pwm_ramp.sv
// motor_pwm_ramp: H-bridge output stage. Turns speed/direction/brake commands
// into the two bridge drive lines, limiting the duty slew rate and inserting a
// dead interval (both lines low) on every direction reversal and brake exit.
module motor_pwm_ramp #(
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 2,
    parameter int RAMP_PERIODS = 4,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PWM_BITS-1:0] cmd_duty,
    input  logic                cmd_dir,
    input  logic                cmd_brake,
    output logic [1:0]          motor,
    output logic [PWM_BITS-1:0] cur_duty,
    output logic                cur_dir,
    output logic                at_target
);

    localparam int PSC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RAMP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam int DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    localparam logic [PSC_W-1:0]    PSC_LAST  = PSC_W'(PRESCALE - 1);
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);
    localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] PCNT_LAST = '1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DEAD  = 2'd1;
    localparam logic [1:0] ST_BRAKE = 2'd2;

    logic [PSC_W-1:0]    psc_q, psc_d;
    logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
    logic                pwm_on_q, pwm_on_d;
    logic [1:0]          state_q, state_d;
    logic [PWM_BITS-1:0] cur_duty_q, cur_duty_d;
    logic                cur_dir_q, cur_dir_d;
    logic [PWM_BITS-1:0] tgt_duty_q, tgt_duty_d;
    logic                tgt_dir_q, tgt_dir_d;
    logic                tgt_brake_q, tgt_brake_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;

    logic                tick;
    logic                boundary;
    logic                accept;
    logic [PWM_BITS-1:0] ramp_goal;

    // Handshake: commands are refused only during the dead interval and reset.
    assign cmd_ready = !rst && (state_q != ST_DEAD);
    assign accept    = cmd_valid && cmd_ready;

    // Period timing: prescaler, tick counter and the period boundary strobe.
    assign tick      = (psc_q == PSC_LAST);
    assign boundary  = tick && (pcnt_q == PCNT_LAST);
    // A pending reversal ramps the duty down to zero before the dead interval.
    assign ramp_goal = (tgt_dir_q == cur_dir_q) ? tgt_duty_q : '0;

    // Next-state logic for counters, targets, applied duty/direction and state.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        psc_d       = tick ? '0 : psc_q + 1'b1;
        pcnt_d      = tick ? pcnt_q + 1'b1 : pcnt_q;
        pwm_on_d    = (pcnt_q < cur_duty_q);
        state_d     = state_q;
        cur_duty_d  = cur_duty_q;
        cur_dir_d   = cur_dir_q;
        tgt_duty_d  = tgt_duty_q;
        tgt_dir_d   = tgt_dir_q;
        tgt_brake_d = tgt_brake_q;
        ramp_cnt_d  = ramp_cnt_q;
        dead_cnt_d  = dead_cnt_q;

        if (accept) begin
            tgt_brake_d = cmd_brake;
            if (!cmd_brake) begin
                tgt_duty_d = cmd_duty;
                tgt_dir_d  = cmd_dir;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (cur_duty_q == ramp_goal) begin
                    ramp_cnt_d = '0;
                end
                if (boundary) begin
                    if (tgt_brake_q) begin
                        state_d    = ST_BRAKE;
                        cur_duty_d = '0;
                        ramp_cnt_d = '0;
                    end else if ((tgt_dir_q != cur_dir_q) && (cur_duty_q == '0)) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = '0;
                        ramp_cnt_d = '0;
                    end else if (cur_duty_q != ramp_goal) begin
                        if (ramp_cnt_q == RAMP_LAST) begin
                            ramp_cnt_d = '0;
                            cur_duty_d = (cur_duty_q < ramp_goal) ? cur_duty_q + 1'b1
                                                                  : cur_duty_q - 1'b1;
                        end else begin
                            ramp_cnt_d = ramp_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_DEAD: begin
                if (boundary) begin
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_d    = ST_RUN;
                        cur_dir_d  = tgt_dir_q;
                        dead_cnt_d = '0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                    end
                end
            end
            ST_BRAKE: begin
                if (boundary && !tgt_brake_q) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            psc_q       <= '0;
            pcnt_q      <= '0;
            pwm_on_q    <= 1'b0;
            state_q     <= ST_RUN;
            cur_duty_q  <= '0;
            cur_dir_q   <= 1'b0;
            tgt_duty_q  <= '0;
            tgt_dir_q   <= 1'b0;
            tgt_brake_q <= 1'b0;
            ramp_cnt_q  <= '0;
            dead_cnt_q  <= '0;
        end else begin
            psc_q       <= psc_d;
            pcnt_q      <= pcnt_d;
            pwm_on_q    <= pwm_on_d;
            state_q     <= state_d;
            cur_duty_q  <= cur_duty_d;
            cur_dir_q   <= cur_dir_d;
            tgt_duty_q  <= tgt_duty_d;
            tgt_dir_q   <= tgt_dir_d;
            tgt_brake_q <= tgt_brake_d;
            ramp_cnt_q  <= ramp_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
        end
    end

    // Bridge drive decode: only BRAKE ever drives both lines high.
    always_comb begin
        case (state_q)
            ST_RUN:   motor = cur_dir_q ? {pwm_on_q, 1'b0} : {1'b0, pwm_on_q};
            ST_BRAKE: motor = 2'b11;
            default:  motor = 2'b00;
        endcase
    end

    assign cur_duty  = cur_duty_q;
    assign cur_dir   = cur_dir_q;
    assign at_target = (state_q == ST_RUN) && !tgt_brake_q &&
                       (cur_duty_q == tgt_duty_q) && (cur_dir_q == tgt_dir_q);

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// tb_motor_pwm_ramp: directed bench for motor_pwm_ramp with a 16-cycle period
// (PWM_BITS=4, PRESCALE=1, RAMP_PERIODS=1, DEAD_PERIODS=2).
module tb_motor_pwm_ramp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_duty = 4'd0;
    logic       cmd_dir = 1'b0;
    logic       cmd_brake = 1'b0;
    logic [1:0] motor;
    logic [3:0] cur_duty;
    logic       cur_dir;
    logic       at_target;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int p00, p01, p10, p11, p_nr, p_at;

    motor_pwm_ramp #(
        .PWM_BITS(4), .PRESCALE(1), .RAMP_PERIODS(1), .DEAD_PERIODS(2)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .cmd_brake(cmd_brake),
        .motor(motor), .cur_duty(cur_duty), .cur_dir(cur_dir), .at_target(at_target)
    );

    always #5 clk = ~clk;

    // Bench-side period phase: cyc % 16 == 0 marks the first cycle of a period.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Present a command for one clock edge (cleared by period_stats).
    task automatic set_cmd(input logic [3:0] duty, input logic dir, input logic brake);
        cmd_duty  = duty;
        cmd_dir   = dir;
        cmd_brake = brake;
        cmd_valid = 1'b1;
    endtask

    // Sample one full period starting at a boundary; ends at the next boundary.
    task automatic period_stats();
        p00 = 0; p01 = 0; p10 = 0; p11 = 0; p_nr = 0; p_at = 0;
        for (int i = 0; i < 16; i++) begin
            case (motor)
                2'b00:   p00++;
                2'b01:   p01++;
                2'b10:   p10++;
                default: p11++;
            endcase
            if (cmd_ready !== 1'b1) p_nr++;
            if (at_target === 1'b1) p_at++;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready_low: got %0d expected 0", cmd_ready); end
        n_checks++; if (motor !== 2'b00) begin n_errors++; $display("FAIL rst_motor: got %0d expected 0", motor); end
        rst = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready_high: got %0d expected 1", cmd_ready); end
        n_checks++; if (cur_duty !== 4'd0) begin n_errors++; $display("FAIL rst_duty: got %0d expected 0", cur_duty); end
        n_checks++; if (cur_dir !== 1'b0) begin n_errors++; $display("FAIL rst_dir: got %0d expected 0", cur_dir); end
        n_checks++; if (at_target !== 1'b1) begin n_errors++; $display("FAIL rst_at_target: got %0d expected 1", at_target); end
    endtask

    task automatic test_ramp_up();
        set_cmd(4'd4, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            period_stats();
            n_checks++; if (cur_duty !== 4'(k)) begin n_errors++; $display("FAIL up_duty_%0d: got %0d expected %0d", k, cur_duty, k); end
            n_checks++; if (at_target !== (k == 4)) begin n_errors++; $display("FAIL up_at_target_%0d: got %0d expected %0d", k, at_target, k == 4); end
        end
        period_stats();
        n_checks++; if (p01 !== 4) begin n_errors++; $display("FAIL up_steady_fwd: got %0d expected 4", p01); end
        n_checks++; if (p10 + p11 !== 0) begin n_errors++; $display("FAIL up_steady_rev: got %0d expected 0", p10 + p11); end
    endtask

    task automatic test_reversal();
        int n11 = 0;
        int nr = 0;
        int on = 0;
        set_cmd(4'd3, 1'b0, 1'b0);
        period_stats();
        n_checks++; if (cur_duty !== 4'd3) begin n_errors++; $display("FAIL rev_start_duty: got %0d expected 3", cur_duty); end
        set_cmd(4'd2, 1'b1, 1'b0);
        for (int k = 2; k >= 0; k--) begin
            period_stats();
            n11 += p11;
            n_checks++; if (cur_duty !== 4'(k)) begin n_errors++; $display("FAIL rev_down_%0d: got %0d expected %0d", k, cur_duty, k); end
        end
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rev_run_at_zero: got %0d expected 1", cmd_ready); end
        period_stats();
        n11 += p11;
        n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL rev_dead_entry: got %0d expected 0", cmd_ready); end
        for (int k = 0; k < 2; k++) begin
            period_stats();
            n11 += p11;
            nr  += p_nr;
            on  += 16 - p00;
        end
        n_checks++; if (nr !== 32) begin n_errors++; $display("FAIL rev_dead_notready: got %0d expected 32", nr); end
        n_checks++; if (on !== 0) begin n_errors++; $display("FAIL rev_dead_motor: got %0d expected 0", on); end
        n_checks++; if (cur_dir !== 1'b1) begin n_errors++; $display("FAIL rev_new_dir: got %0d expected 1", cur_dir); end
        n_checks++; if (cur_duty !== 4'd0) begin n_errors++; $display("FAIL rev_restart_duty: got %0d expected 0", cur_duty); end
        period_stats();
        n11 += p11;
        period_stats();
        n11 += p11;
        n_checks++; if (p10 !== 1 || p01 !== 0) begin n_errors++; $display("FAIL rev_pulse1: got %0d expected 1", p10); end
        period_stats();
        n11 += p11;
        n_checks++; if (p10 !== 2 || p01 !== 0) begin n_errors++; $display("FAIL rev_pulse2: got %0d expected 2", p10); end
        n_checks++; if (p_at !== 16) begin n_errors++; $display("FAIL rev_at_target: got %0d expected 16", p_at); end
        n_checks++; if (n11 !== 0) begin n_errors++; $display("FAIL rev_never_11: got %0d expected 0", n11); end
    endtask

    task automatic test_brake();
        int guard = 0;
        int nr = 0;
        int on = 0;
        set_cmd(4'd5, 1'b0, 1'b0);
        period_stats();
        while (!at_target && guard < 24) begin period_stats(); guard++; end
        n_checks++; if (at_target !== 1'b1 || cur_duty !== 4'd5 || cur_dir !== 1'b0) begin n_errors++; $display("FAIL brk_run5: got duty %0d expected 5", cur_duty); end
        period_stats();
        n_checks++; if (p01 !== 5) begin n_errors++; $display("FAIL brk_run5_pwm: got %0d expected 5", p01); end
        set_cmd(4'd0, 1'b0, 1'b1);
        period_stats();
        n_checks++; if (p11 !== 0) begin n_errors++; $display("FAIL brk_no_early: got %0d expected 0", p11); end
        n_checks++; if (motor !== 2'b11) begin n_errors++; $display("FAIL brk_motor: got %0d expected 3", motor); end
        n_checks++; if (cur_duty !== 4'd0) begin n_errors++; $display("FAIL brk_duty: got %0d expected 0", cur_duty); end
        set_cmd(4'd9, 1'b1, 1'b1);
        period_stats();
        n_checks++; if (p11 !== 16 || motor !== 2'b11) begin n_errors++; $display("FAIL brk_rebrake: got %0d expected 16", p11); end
        set_cmd(4'd1, 1'b0, 1'b0);
        period_stats();
        n_checks++; if (p11 !== 16) begin n_errors++; $display("FAIL brk_hold: got %0d expected 16", p11); end
        n_checks++; if (motor !== 2'b00 || cmd_ready !== 1'b0) begin n_errors++; $display("FAIL brk_exit_dead: got %0d expected 0", motor); end
        for (int k = 0; k < 2; k++) begin
            period_stats();
            nr += p_nr;
            on += 16 - p00;
        end
        n_checks++; if (nr !== 32 || on !== 0) begin n_errors++; $display("FAIL brk_dead_len: got %0d expected 32", nr); end
        period_stats();
        n_checks++; if (cur_duty !== 4'd1) begin n_errors++; $display("FAIL brk_ramp1: got %0d expected 1", cur_duty); end
        period_stats();
        n_checks++; if (p01 !== 1 || p10 !== 0) begin n_errors++; $display("FAIL brk_pwm1: got %0d expected 1", p01); end
    endtask

    task automatic test_extremes();
        int guard = 0;
        set_cmd(4'd15, 1'b0, 1'b0);
        period_stats();
        while (!at_target && guard < 24) begin period_stats(); guard++; end
        n_checks++; if (cur_duty !== 4'd15) begin n_errors++; $display("FAIL max_duty: got %0d expected 15", cur_duty); end
        period_stats();
        n_checks++; if (p01 !== 15) begin n_errors++; $display("FAIL max_pwm: got %0d expected 15", p01); end
        set_cmd(4'd0, 1'b0, 1'b0);
        period_stats();
        guard = 0;
        while (!at_target && guard < 24) begin period_stats(); guard++; end
        n_checks++; if (cur_duty !== 4'd0) begin n_errors++; $display("FAIL zero_duty: got %0d expected 0", cur_duty); end
        period_stats();
        n_checks++; if (p00 !== 16) begin n_errors++; $display("FAIL zero_pwm: got %0d expected 16", p00); end
    endtask

    task automatic test_same_cmd();
        set_cmd(4'd0, 1'b0, 1'b0);
        period_stats();
        n_checks++; if (p_at !== 16) begin n_errors++; $display("FAIL same_at_target: got %0d expected 16", p_at); end
        n_checks++; if (cur_duty !== 4'd0 || p00 !== 16) begin n_errors++; $display("FAIL same_no_change: got %0d expected 0", cur_duty); end
    endtask

    task automatic test_mid_reset();
        set_cmd(4'd6, 1'b0, 1'b0);
        period_stats();
        period_stats();
        n_checks++; if (cur_duty !== 4'd2) begin n_errors++; $display("FAIL mrst_pre_duty: got %0d expected 2", cur_duty); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (motor !== 2'b00) begin n_errors++; $display("FAIL mrst_motor: got %0d expected 0", motor); end
        n_checks++; if (cur_duty !== 4'd0) begin n_errors++; $display("FAIL mrst_duty: got %0d expected 0", cur_duty); end
        rst = 1'b0;
        #1;
        n_checks++; if (at_target !== 1'b1) begin n_errors++; $display("FAIL mrst_target: got %0d expected 1", at_target); end
        period_stats();
        period_stats();
        n_checks++; if (cur_duty !== 4'd0 || p00 !== 16) begin n_errors++; $display("FAIL mrst_no_ramp: got %0d expected 0", cur_duty); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reversal();
        test_brake();
        test_extremes();
        test_same_cmd();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
